md_sched: RTL and testbench

- Sequencer for the multiply/divide unit and the HI/LO register pair of the pipelined MIPS core.
- Accepts mult/multu/div/divu/mthi/mtlo commands issued from the E stage and runs each multi-cycle operation for a fixed latency.
- Raises a pipeline stall request while a multiply/divide instruction in the D stage would collide with an operation in flight.
- Sits beside the ALU in E. The hazard unit ORs `stall` into the global stall.

---
 rtl/md_sched.sv | 164 ++++++++++++++++
 tb/tb_md_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer and HI/LO register pair for the MIPS E stage.
// Results are computed when a command is accepted and held in hi_nx/lo_nx.
// They are committed to HI/LO after a fixed busy latency.
// Optional build macro MD_CANCEL_EN adds a 'cancel' input that aborts an operation
// in flight and suppresses a start in the same cycle.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic [31:0]       hi_nx_q, hi_nx_d, lo_nx_q, lo_nx_d;
    logic              div0_q, div0_d;
    logic              cancel_w;

    logic              is_md_op;
    logic [31:0]       res_hi, res_lo;
    logic [63:0]       prod_u, prod_s;
    logic [31:0]       div_safe, a_mag, b_mag, q_mag, r_mag, q_u, r_u;

`ifdef MD_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    assign is_md_op = (md_op >= OpMult) && (md_op <= OpDivu);
    assign busy     = (state_q == StRun);
    assign stall    = d_is_md && (busy || (start && is_md_op));
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Arithmetic for the command presented this cycle; divisor forced to 1 when zero
    // so the dividers never see x, the div0 flag blocks the write-back instead.
    always_comb begin
        prod_u   = {32'b0, rs_data} * {32'b0, rt_data};
        prod_s   = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
        div_safe = (rt_data == 32'd0) ? 32'd1 : rt_data;
        // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
        a_mag    = rs_data[31] ? (32'd0 - rs_data) : rs_data;
        b_mag    = div_safe[31] ? (32'd0 - div_safe) : div_safe;
        q_mag    = a_mag / b_mag;
        r_mag    = a_mag % b_mag;
        q_u      = rs_data / div_safe;
        r_u      = rs_data % div_safe;
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        case (md_op)
            OpMult: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OpMultu: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OpDiv: begin
                res_lo = (rs_data[31] ^ div_safe[31]) ? (32'd0 - q_mag) : q_mag;
                res_hi = rs_data[31] ? (32'd0 - r_mag) : r_mag;
            end
            OpDivu: begin
                res_lo = q_u;
                res_hi = r_u;
            end
            default: ;
        endcase
    end

    // Next-state: accept commands in idle, count down in run, commit on the last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_nx_d = hi_nx_q;
        lo_nx_d = lo_nx_q;
        div0_d  = div0_q;
        unique case (state_q)
            StIdle: begin
                if (start && !cancel_w) begin
                    if (is_md_op) begin
                        hi_nx_d = res_hi;
                        lo_nx_d = res_lo;
                        div0_d  = (md_op == OpDiv || md_op == OpDivu) && (rt_data == 32'd0);
                        cnt_d   = (md_op == OpMult || md_op == OpMultu) ?
                                  CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                        state_d = StRun;
                    end else if (md_op == OpMthi) begin
                        hi_d = rs_data;
                    end else if (md_op == OpMtlo) begin
                        lo_d = rs_data;
                    end
                end
            end
            StRun: begin
                if (cancel_w) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (!div0_q) begin
                        hi_d = hi_nx_q;
                        lo_d = lo_nx_q;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and register file update; reset discards any pending result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_nx_q <= '0;
            lo_nx_q <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_nx_q <= hi_nx_d;
            lo_nx_q <= lo_nx_d;
            div0_q  <= div0_d;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed bench for md_sched with a result scoreboard.
// Build with MD_CANCEL_EN defined to also exercise the cancel input.
module tb_md_sched;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        cancel;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_data, rt_data;
    logic        d_is_md;
    logic        busy, stall;
    logic [31:0] hi, lo;

    logic [63:0] sb[$];
    logic [63:0] exp_v;
    int          nchk = 0;
    int          nfail = 0;
    int          cnt;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef MD_CANCEL_EN
        .cancel  (cancel),
`endif
        .start   (start),
        .md_op   (md_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .d_is_md (d_is_md),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one command for a single edge; returns at t+1 (first busy cycle).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        md_op   = op;
        rs_data = a;
        rt_data = b;
        step();
        start   = 1'b0;
        md_op   = 3'd0;
    endtask

    // Count busy cycles (bounded), then compare HI/LO against the scoreboard.
    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int n);
        int c;
        sb.push_back(exp);
        issue(op, a, b);
        c = 0;
        while (busy === 1'b1 && c < 60) begin
            c++;
            step();
        end
        check({tag, " busy cycles"}, 64'(c), 64'(n));
        check({tag, " hi/lo"}, {hi, lo}, sb.pop_front());
    endtask

    initial begin
        reset = 1'b1; cancel = 1'b0; start = 1'b0; md_op = 3'd0;
        rs_data = '0; rt_data = '0; d_is_md = 1'b0;
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset stall", 64'(stall), 64'd0);
        check("reset hi/lo", {hi, lo}, 64'd0);
        step();
        step();
        reset = 1'b0;
        step();

        run_md("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, MC);
        run_md("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, MC);
        run_md("div", 3'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, DC);
        run_md("div0", 3'd3, 32'd1234, 32'd0, 64'hFFFFFFFF_FFFFFFFD, DC);
        run_md("divmin", 3'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, DC);

        // mthi/mtlo back to back with a md instruction in D: no busy, no stall
        d_is_md = 1'b1;
        start = 1'b1; md_op = 3'd5; rs_data = 32'h12345678;
        #1;
        check("mthi stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        md_op = 3'd6; rs_data = 32'h9ABCDEF0;
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi hi/lo", {hi, lo}, 64'h12345678_80000000);
        check("mtlo stall", 64'(stall), 64'd0);
        step();
        start = 1'b0; md_op = 3'd0;
        check("mtlo busy", 64'(busy), 64'd0);
        check("mtlo hi/lo", {hi, lo}, 64'h12345678_9ABCDEF0);

        // no-op commands leave everything alone
        start = 1'b1; md_op = 3'd0; rs_data = 32'hDEADBEEF;
        step();
        md_op = 3'd7;
        step();
        start = 1'b0; md_op = 3'd0;
        check("nop busy", 64'(busy), 64'd0);
        check("nop hi/lo", {hi, lo}, 64'h12345678_9ABCDEF0);

        // divu with a md instruction in D; a stray start mid-flight must be ignored
        sb.push_back({32'd2, 32'd14});
        start = 1'b1; md_op = 3'd4; rs_data = 32'd100; rt_data = 32'd7;
        #1;
        check("divu stall start", 64'(stall), 64'd1);
        step();
        start = 1'b0; md_op = 3'd0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 60) begin
            check("divu stall busy", 64'(stall), 64'd1);
            cnt++;
            if (cnt == 3) begin
                $display("info: start issued while busy (protocol violation, must be ignored)");
                start = 1'b1; md_op = 3'd1; rs_data = 32'd5; rt_data = 32'd7;
            end else begin
                start = 1'b0; md_op = 3'd0;
            end
            step();
        end
        start = 1'b0; md_op = 3'd0;
        check("divu busy cycles", 64'(cnt), 64'(DC));
        check("divu stall done", 64'(stall), 64'd0);
        check("divu hi/lo", {hi, lo}, sb.pop_front());
        step();
        check("divu no rerun", 64'(busy), 64'd0);
        d_is_md = 1'b0;

        // asynchronous reset during the 4th busy cycle of a div
        issue(3'd3, 32'd100, 32'd3);
        step();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst hi/lo", {hi, lo}, 64'd0);
        step();
        reset = 1'b0;
        step();
        check("post rst busy", 64'(busy), 64'd0);
        check("post rst hi/lo", {hi, lo}, 64'd0);

`ifdef MD_CANCEL_EN
        issue(3'd6, 32'h00000055, 32'd0);
        exp_v = {32'd0, 32'h00000055};
        issue(3'd1, 32'd7, 32'd9);
        step();
        step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("cancel busy", 64'(busy), 64'd0);
        check("cancel hi/lo", {hi, lo}, exp_v);
        cancel = 1'b1;
        issue(3'd5, 32'hCAFEF00D, 32'd0);
        cancel = 1'b0;
        check("cancel mthi", {hi, lo}, exp_v);
        cancel = 1'b1;
        issue(3'd3, 32'd9, 32'd2);
        cancel = 1'b0;
        check("cancel start busy", 64'(busy), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
